// File: rtl/rot_reservation_station_pkg.sv
// Shared types for the rotate reservation station: decoded control, tagged operands,
// entry lifecycle states and the CDB snoop helper used on dispatch and wakeup.
package rot_reservation_station_pkg;

  localparam int RS_ID_WIDTH_MAX = 8;
  localparam int NUM_SRC         = 4;
  localparam int SRC_XER         = 3;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] sh;
    logic [4:0] mb;
    logic [4:0] me;
    logic       rc;
  } rotate_decode_t;

  typedef struct packed {
    logic                       valid;
    logic [RS_ID_WIDTH_MAX-1:0] tag;
    logic [31:0]                value;
  } rs_operand_t;

  typedef enum logic [1:0] {
    RS_FREE    = 2'd0,
    RS_WAITING = 2'd1,
    RS_ISSUED  = 2'd2
  } rs_entry_state_t;

  // A missing source takes the broadcast value when its producer tag is on the bus.
  function automatic rs_operand_t snoop_operand(rs_operand_t src, logic hit, logic [31:0] value);
    rs_operand_t res;
    res       = src;
    res.valid = src.valid | hit;
    res.value = (!src.valid && hit) ? value : src.value;
    return res;
  endfunction

endpackage

// File: rtl/rot_reservation_station_age_matrix_select.sv
// Age-matrix oldest-first selector: tracks allocation order of N slots and returns
// the oldest slot among a ready vector as a one-hot.
module age_matrix_select
  import rot_reservation_station_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic [N-1:0] alloc_i,
  input  logic [N-1:0] ready_i,
  output logic [N-1:0] oldest_o
);

  // age_q[i][j] set means slot i was allocated before slot j
  logic [N-1:0] age_q [N];
  logic [N-1:0] age_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        age_d[i][j] = alloc_i[j] ? (i != j) : (alloc_i[i] ? 1'b0 : age_q[i][j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) age_q[i] <= age_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      oldest_o[i] = ready_i[i] & (&(age_q[i] | ~ready_i | (N'(1) << i)));
    end
  end

endmodule

// File: rtl/rot_reservation_station.sv
// Reservation station for the rotate unit: holds dispatched ops until all four sources
// are valid, snoops the CDB for missing sources and issues the oldest ready op.
module rot_reservation_station
  import rot_reservation_station_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_ENTRIES = 4,
  parameter int RS_ID_BASE  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_result_reg_addr,
  input  rotate_decode_t         in_control,
  input  rs_operand_t            in_op1,
  input  rs_operand_t            in_op2,
  input  rs_operand_t            in_target,
  input  rs_operand_t            in_xer,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  input  logic                   cdb_xer_valid,
  input  logic [31:0]            cdb_xer,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RS_ID_WIDTH-1:0] out_rs_id,
  output logic [4:0]             out_result_reg_addr,
  output logic [31:0]            out_op1,
  output logic [31:0]            out_op2,
  output logic [31:0]            out_target,
  output logic [31:0]            out_xer,
  output rotate_decode_t         out_control
);

  rs_entry_state_t state_q [NUM_ENTRIES];
  rs_entry_state_t state_d [NUM_ENTRIES];
  rs_operand_t     src_q   [NUM_ENTRIES][NUM_SRC];
  rs_operand_t     src_d   [NUM_ENTRIES][NUM_SRC];
  logic [4:0]      addr_q  [NUM_ENTRIES];
  logic [4:0]      addr_d  [NUM_ENTRIES];
  rotate_decode_t  ctrl_q  [NUM_ENTRIES];
  rotate_decode_t  ctrl_d  [NUM_ENTRIES];
  logic            in_ready_q, in_ready_d;

  logic                   out_valid_q;
  logic [RS_ID_WIDTH-1:0] out_rs_id_q;
  logic [4:0]             out_addr_q;
  logic [31:0]            out_ops_q [NUM_SRC];
  rotate_decode_t         out_control_q;

  logic [NUM_ENTRIES-1:0]       free_s, ready_s, alloc_s, sel_s;
  logic                         load_en_s, issue_s;
  rs_operand_t                  disp_src_s [NUM_SRC];
  logic [RS_ID_WIDTH_MAX-1:0]   cdb_tag_s;
  logic [RS_ID_WIDTH-1:0]       iss_id_s;
  logic [4:0]                   iss_addr_s;
  logic [$bits(rotate_decode_t)-1:0] iss_ctrl_s;
  logic [31:0]                  iss_ops_s [NUM_SRC];

  function automatic logic src_hit(logic [RS_ID_WIDTH_MAX-1:0] tag, int src);
    return cdb_valid && (tag == cdb_tag_s) && ((src != SRC_XER) || cdb_xer_valid);
  endfunction

  function automatic logic [31:0] src_value(int src);
    return (src == SRC_XER) ? cdb_xer : cdb_result;
  endfunction

  assign cdb_tag_s     = RS_ID_WIDTH_MAX'(cdb_rs_id);
  assign disp_src_s[0] = in_op1;
  assign disp_src_s[1] = in_op2;
  assign disp_src_s[2] = in_target;
  assign disp_src_s[3] = in_xer;
  assign load_en_s     = ~out_valid_q | out_ready;
  assign issue_s       = load_en_s & (|ready_s);
  // lowest FREE index wins the dispatch; isolate the lowest set bit
  assign alloc_s       = (in_valid & in_ready_q) ? (free_s & (~free_s + NUM_ENTRIES'(1))) : '0;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      free_s[i]  = (state_q[i] == RS_FREE);
      ready_s[i] = (state_q[i] == RS_WAITING);
      for (int s = 0; s < NUM_SRC; s++) ready_s[i] = ready_s[i] & src_q[i][s].valid;
    end
  end

  age_matrix_select #(.N(NUM_ENTRIES)) u_age (
    .clk      (clk),
    .rst_i    (rst | flush),
    .alloc_i  (alloc_s),
    .ready_i  (ready_s),
    .oldest_o (sel_s)
  );

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      addr_d[i]  = addr_q[i];
      ctrl_d[i]  = ctrl_q[i];
      for (int s = 0; s < NUM_SRC; s++) begin
        src_d[i][s] = snoop_operand(src_q[i][s], src_hit(src_q[i][s].tag, s), src_value(s));
      end
      case (state_q[i])
        RS_FREE: begin
          if (alloc_s[i]) begin
            state_d[i] = RS_WAITING;
            addr_d[i]  = in_result_reg_addr;
            ctrl_d[i]  = in_control;
            for (int s = 0; s < NUM_SRC; s++) begin
              src_d[i][s] = snoop_operand(disp_src_s[s], src_hit(disp_src_s[s].tag, s), src_value(s));
            end
          end else begin
            state_d[i] = RS_FREE;
          end
        end
        RS_WAITING: state_d[i] = (issue_s && sel_s[i]) ? RS_ISSUED : RS_WAITING;
        RS_ISSUED:  state_d[i] = (cdb_valid && (cdb_rs_id == RS_ID_WIDTH'(RS_ID_BASE + i)))
                                 ? RS_FREE : RS_ISSUED;
        default:    state_d[i] = RS_FREE;
      endcase
    end
    in_ready_d = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) in_ready_d = in_ready_d | (state_d[i] == RS_FREE);
  end

  // one-hot OR mux of the selected entry into the issue register
  always_comb begin
    iss_id_s   = '0;
    iss_addr_s = '0;
    iss_ctrl_s = '0;
    for (int s = 0; s < NUM_SRC; s++) iss_ops_s[s] = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      iss_id_s   = iss_id_s | (RS_ID_WIDTH'(RS_ID_BASE + i) & {RS_ID_WIDTH{sel_s[i]}});
      iss_addr_s = iss_addr_s | (addr_q[i] & {5{sel_s[i]}});
      iss_ctrl_s = iss_ctrl_s | (ctrl_q[i] & {$bits(rotate_decode_t){sel_s[i]}});
      for (int s = 0; s < NUM_SRC; s++) begin
        iss_ops_s[s] = iss_ops_s[s] | (src_q[i][s].value & {32{sel_s[i]}});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= RS_FREE;
        addr_q[i]  <= '0;
        ctrl_q[i]  <= '0;
        for (int s = 0; s < NUM_SRC; s++) src_q[i][s] <= '0;
      end
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_rs_id_q   <= '0;
      out_addr_q    <= '0;
      out_control_q <= '0;
      for (int s = 0; s < NUM_SRC; s++) out_ops_q[s] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        addr_q[i]  <= addr_d[i];
        ctrl_q[i]  <= ctrl_d[i];
        for (int s = 0; s < NUM_SRC; s++) src_q[i][s] <= src_d[i][s];
      end
      in_ready_q <= in_ready_d;
      if (load_en_s) begin
        out_valid_q <= issue_s;
        if (issue_s) begin
          out_rs_id_q   <= iss_id_s;
          out_addr_q    <= iss_addr_s;
          out_control_q <= rotate_decode_t'(iss_ctrl_s);
          for (int s = 0; s < NUM_SRC; s++) out_ops_q[s] <= iss_ops_s[s];
        end
      end
    end
  end

  assign in_ready            = in_ready_q;
  assign out_valid           = out_valid_q;
  assign out_rs_id           = out_rs_id_q;
  assign out_result_reg_addr = out_addr_q;
  assign out_op1             = out_ops_q[0];
  assign out_op2             = out_ops_q[1];
  assign out_target          = out_ops_q[2];
  assign out_xer             = out_ops_q[3];
  assign out_control         = out_control_q;

endmodule
